// File: rtl/arb_rr_2to1_buf.sv
// Two-input round-robin arbiter that feeds a single-entry output buffer.
// out_src carries the registered index of the winning port for the downstream 2:1 mux select.
module arb_rr_2to1_buf #(
  parameter int unsigned nbits = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in0_val,
  output logic             in0_rdy,
  input  logic [nbits-1:0] in0_msg,
  input  logic             in1_val,
  output logic             in1_rdy,
  input  logic [nbits-1:0] in1_msg,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [nbits-1:0] out_msg,
  output logic             out_src
);

  logic             buf_full_q, buf_full_d;
  logic [nbits-1:0] buf_msg_q,  buf_msg_d;
  logic             buf_src_q,  buf_src_d;
  logic             pri_q,      pri_d;

  logic can_accept;
  logic grant;
  logic xfer_in;
  logic xfer_out;

  // Both ready signals are gated by reset so that no transfer completes while reset is held.
  always_comb begin
    can_accept = !buf_full_q || out_rdy;
    grant      = (in0_val && in1_val) ? pri_q : in1_val;
    in0_rdy    = reset && can_accept && in0_val && !grant;
    in1_rdy    = reset && can_accept && in1_val &&  grant;
    xfer_in    = in0_rdy || in1_rdy;
    xfer_out   = reset && buf_full_q && out_rdy;
  end

  always_comb begin
    buf_full_d = buf_full_q;
    buf_msg_d  = buf_msg_q;
    buf_src_d  = buf_src_q;
    pri_d      = pri_q;
    if (xfer_in) begin
      buf_full_d = 1'b1;
      buf_msg_d  = grant ? in1_msg : in0_msg;
      buf_src_d  = grant;
      pri_d      = !grant;
    end else if (xfer_out) begin
      buf_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      buf_full_q <= 1'b0;
      buf_msg_q  <= '0;
      buf_src_q  <= 1'b0;
      pri_q      <= 1'b0;
    end else begin
      buf_full_q <= buf_full_d;
      buf_msg_q  <= buf_msg_d;
      buf_src_q  <= buf_src_d;
      pri_q      <= pri_d;
    end
  end

  assign out_val = buf_full_q;
  assign out_msg = buf_msg_q;
  assign out_src = buf_src_q;

endmodule

// File: doc/arb_rr_2to1_buf.md
Name: arb_rr_2to1_buf

Overview:
- Registered two-input round-robin arbiter that sits directly upstream of the 2:1 datapath mux stage.
- Accepts messages from two val/rdy producers and grants one per cycle.
- Holds the winner in a single-entry output buffer and presents it downstream with a val/rdy interface.
- Also presents the registered winning-port index on out_src. Downstream logic drives the 2:1 mux select from out_src.

Parameters:
- nbits, 8, width of every message port

Ports:
- clk      input   1      clock; all state updates on rising edge
- reset    input   1      synchronous, active-low reset (reset==0 resets on rising clk edge)
- in0_val  input   1      producer 0 has a valid message
- in0_rdy  output  1      block accepts in0_msg this cycle
- in0_msg  input   nbits  producer 0 message
- in1_val  input   1      producer 1 has a valid message
- in1_rdy  output  1      block accepts in1_msg this cycle
- in1_msg  input   nbits  producer 1 message
- out_val  output  1      output buffer holds a valid message
- out_rdy  input   1      consumer accepts the message this cycle
- out_msg  output  nbits  buffered message
- out_src  output  1      index (0/1) of the port that supplied out_msg

Behaviour:
- Transfer rules:
  - A transfer occurs on any interface when val && rdy are both high at the rising edge.
  - Producers must hold msg stable while val is high and rdy is low.
- State:
  - buf_full (1b), buf_msg (nbits), buf_src (1b), pri (1b).
  - pri is the input that wins when both inputs request.
- Reset (reset==0 at edge), with reset dominating all other events:
  - buf_full=0, buf_msg=0, buf_src=0, pri=0.
  - out_val=0, out_msg=0, out_src=0.
  - in0_rdy=0 and in1_rdy=0 while reset==0.
  - A reset mid-operation discards any buffered message. No transfer completes in a cycle where reset==0.
- Outputs: out_val=buf_full, out_msg=buf_msg, out_src=buf_src. All three are purely registered.
- can_accept = !buf_full || out_rdy, so the block accepts while draining in the same cycle.
- Grant (combinational):
  - Only in0_val high: grant 0.
  - Only in1_val high: grant 1.
  - Both high: grant pri.
  - Neither high: no grant.
- Ready signals:
  - in0_rdy = can_accept && grant==0 && in0_val; in1_rdy is the same for port 1.
  - At most one in*_rdy is high in any cycle.
  - in*_rdy depends combinationally on in*_val and out_rdy. There is no combinational path from in*_msg to any output.
- On an input transfer from port i:
  - buf_msg<=in_i_msg, buf_src<=i, buf_full<=1, pri<=~i.
  - pri changes only on an input transfer, never on idle cycles or output-only cycles.
- On an output transfer with no input transfer: buf_full<=0. buf_msg and buf_src hold their last values.
- Simultaneous output and input transfer: the buffer is overwritten with the new message and buf_full stays 1. This gives full throughput of one message per cycle.
- Buffer full and out_rdy=0: both in*_rdy are 0 and all state holds.
- Latency: a message accepted at edge N appears on out_* in the cycle after edge N (one-cycle latency).
- Fairness: under continuous requests from both ports with out_rdy=1, grants alternate 0,1,0,1,... starting from the current pri.
- Wrap-around: pri is a single bit and toggles freely; there is no counter overflow condition.

Test Plan:
- Reset, then idle: hold reset=0 for 2 cycles while in0_val=in1_val=1. Required: in0_rdy=in1_rdy=0 throughout. After reset=1 with no inputs valid: out_val=0, out_msg=0, out_src=0.
- Single port: in0_val=1 with in0_msg=0xA5, out_rdy=1. Required: in0_rdy=1; next cycle out_val=1, out_msg=0xA5, out_src=0. Then in0_val=0 → out_val=0 one cycle later.
- Contention: in0_val=in1_val=1 for 4 cycles with msgs 0x10 and 0x21, out_rdy=1, starting from reset (pri=0). Required: out_src sequence 0,1,0,1; out_msg sequence 0x10,0x21,0x10,0x21; one transfer per cycle.
- Backpressure: fill the buffer with 0x3C, then hold out_rdy=0 for 3 cycles with in1_val=1 and in1_msg=0x77. Required: in1_rdy=0 and out_msg=0x3C held throughout. Then out_rdy=1 → in1_rdy=1 in the same cycle, and out_msg=0x77 on the next cycle.
- Pri retention: only in1 requests for 2 transfers (pri becomes 0), then idle 3 cycles, then both request. Required: port 0 wins first.
- Reset mid-operation: with the buffer full (out_val=1, out_msg=0x55), assert reset=0 for 1 cycle. Required: out_val=0, out_msg=0, pri=0 afterward; the next contention grants port 0.
